handshake_rr_arbiter: RTL

//   Shares one downstream ready/valid channel between N_REQ upstream handshake requesters
//   (handshake_arr_0..N_REQ-1) using work-conserving round-robin arbitration.

---
 rtl/handshake_rr_arbiter_pkg.sv | 21 ++
 rtl/handshake_rr_arbiter_if.sv | 29 ++
 rtl/handshake_rr_arbiter_rr_pick.sv | 35 +++
 rtl/handshake_rr_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/handshake_rr_arbiter_pkg.sv
// Shared types and helpers for the handshake round-robin arbiter.
// Optional assertions in the top are enabled with HANDSHAKE_ARB_SVA_EN.
package handshake_arb_pkg;

    // Width of a source index for n requesters (never narrower than 1 bit)
    function automatic int src_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Pointer value after reset: the last requester, so requester 0 is scanned first
    function automatic int reset_ptr(input int n);
        return n - 1;
    endfunction

    // Occupancy of the single registered output stage
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/handshake_rr_arbiter_if.sv
// Bundles the requester-side and consumer-side handshake signals of the arbiter.
// slave: the arbiter itself; master: the requester array plus downstream consumer.
interface handshake_rr_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int WIDTH = 4
);
    import handshake_arb_pkg::*;

    localparam int SRC_W = src_w(N_REQ);

    logic [N_REQ-1:0]       in_valid;
    logic [N_REQ-1:0]       in_ready;
    logic [N_REQ*WIDTH-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [SRC_W-1:0]       out_src;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/handshake_rr_arbiter_rr_pick.sv
// Combinational round-robin select: first requester after ptr, wrapping modulo N_REQ.
module rr_pick
    import handshake_arb_pkg::*;
#(
    parameter  int N_REQ = 3,
    localparam int SRC_W = src_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [SRC_W-1:0] idx,
    output logic             any
);

    localparam logic [SRC_W-1:0] LAST = SRC_W'(N_REQ - 1);

    logic [SRC_W-1:0] cand;

    // Walk ptr+1, ptr+2, ... (wrapping) and keep the first requester found
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (cand == LAST) ? '0 : cand + SRC_W'(1);
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Work-conserving round-robin arbiter feeding one registered ready/valid stage.
// Define HANDSHAKE_ARB_SVA_EN to compile in protocol and fairness assertions.
module handshake_rr_arbiter
    import handshake_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESETN,
    handshake_rr_arbiter_if.slave bus
);

    localparam int               SRC_W     = src_w(N_REQ);
    localparam logic [SRC_W-1:0] RESET_PTR = SRC_W'(reset_ptr(N_REQ));

    arb_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;

    logic [N_REQ-1:0] grant;
    logic [SRC_W-1:0] win_idx;
    logic             win_any;
    logic             can_load;
    logic             transfer;
    logic [WIDTH-1:0] lane [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign lane[gi] = bus.in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (bus.in_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    // The stage can accept a beat when empty or when its current beat leaves this cycle.
    // Ready is held low during reset so nothing is offered a handshake it cannot complete.
    assign can_load     = (state_q == EMPTY) || bus.out_ready;
    assign transfer     = ASYNCRESETN && can_load && win_any;
    assign bus.in_ready = (ASYNCRESETN && can_load) ? grant : '0;

    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;

    // Output stage registers and round-robin pointer
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= EMPTY;
            data_q  <= '0;
            src_q   <= '0;
            ptr_q   <= RESET_PTR;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: load the winner (also when draining), else drain, else hold.
    // ptr only moves on a real transfer, so a stalled winner is not committed.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        if (transfer) begin
            state_d = FULL;
            data_d  = lane[win_idx];
            src_d   = win_idx;
            ptr_d   = win_idx;
        end else if ((state_q == FULL) && bus.out_ready) begin
            state_d = EMPTY;
        end
    end

`ifdef HANDSHAKE_ARB_SVA_EN
    a_ready_onehot0: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        $onehot0(bus.in_ready));

    a_stall_stable: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        (bus.out_valid && !bus.out_ready) |=>
            (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_src)));

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_sva
            logic [3:0] wait_q;

            // Count transfers that went elsewhere while this requester kept waiting
            always_ff @(posedge CLK or negedge ASYNCRESETN) begin
                if (!ASYNCRESETN) begin
                    wait_q <= '0;
                end else if (!bus.in_valid[gi] || bus.in_ready[gi]) begin
                    wait_q <= '0;
                end else if (transfer) begin
                    wait_q <= wait_q + 4'd1;
                end
            end

            a_ready_needs_valid: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
                bus.in_ready[gi] |-> bus.in_valid[gi]);

            a_fair: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
                int'(wait_q) < N_REQ);
        end
    endgenerate
`else
    // Assertions not compiled in this build.
`endif

endmodule
